// File: rtl/alu_seq_pkg.sv
// Shared opcodes and FSM state encoding for the sequential ALU.
package alu_seq_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        MUL  = 3'd1,
        DIV  = 3'd2,
        DFIX = 3'd3,
        DONE = 3'd4
    } state_t;

endpackage

// File: rtl/alu_seq_if.sv
// Request/response handshake bundle between controller, ALU and consumer.
interface alu_seq_if #(
    parameter int unsigned WIDTH = 8
);
    logic                   in_valid;
    logic                   in_ready;
    logic [1:0]             opcode;
    logic                   signed_op;
    logic [WIDTH-1:0]       a;
    logic [WIDTH-1:0]       b;
    logic                   out_valid;
    logic                   out_ready;
    logic [2*WIDTH-1:0]     result;
    logic                   dbz;
    logic                   ovf;

    modport master (
        output in_valid, opcode, signed_op, a, b, out_ready,
        input  in_ready, out_valid, result, dbz, ovf
    );

    modport slave (
        input  in_valid, opcode, signed_op, a, b, out_ready,
        output in_ready, out_valid, result, dbz, ovf
    );
endinterface

// File: rtl/alu_nr_div.sv
// Non-restoring divider on unsigned magnitudes, one iteration per enable.
module alu_nr_div #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             en,
    input  logic             fix,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quo,
    output logic [WIDTH-1:0] rem_c
);

    // Two guard bits: the shifted partial remainder spans (-2D, 2D).
    localparam int unsigned PW = WIDTH + 2;

    logic [PW-1:0]    p_q;
    logic [WIDTH-1:0] q_q;
    logic [PW-1:0]    d_ext;
    logic [PW-1:0]    p_sh;
    logic [PW-1:0]    p_step;
    logic [PW-1:0]    p_fix;

    // Next partial remainder for one iteration, and the final add-back.
    always_comb begin
        d_ext  = PW'(divisor);
        p_sh   = {p_q[PW-2:0], q_q[WIDTH-1]};
        p_step = p_q[PW-1] ? (p_sh + d_ext) : (p_sh - d_ext);
        p_fix  = p_q[PW-1] ? (p_q + d_ext) : p_q;
    end

    // Remainder/quotient shift register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            p_q <= '0;
            q_q <= '0;
        end else if (load) begin
            p_q <= '0;
            q_q <= dividend;
        end else if (en) begin
            p_q <= p_step;
            q_q <= {q_q[WIDTH-2:0], ~p_step[PW-1]};
        end else if (fix) begin
            p_q <= p_fix;
        end
    end

    assign quo   = q_q;
    assign rem_c = p_fix[WIDTH-1:0];

endmodule

// File: rtl/alu_seq_core.sv
// Multi-cycle add/sub/Booth-mul/non-restoring-div ALU with valid/ready on both sides.
module alu_seq_core
    import alu_seq_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
    input  logic    clk,
    input  logic    reset,
    alu_seq_if.slave bus
);

    localparam int unsigned RW = 2 * WIDTH;

    state_t state_q;
    state_t state_n;

    logic             in_ready_q;
    logic             out_valid_q;
    logic [RW-1:0]    result_q;
    logic             dbz_q;
    logic             ovf_q;

    logic             sgn_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [CNT_W-1:0] cnt_q;

    logic [WIDTH:0]   acc_q;
    logic [WIDTH-1:0] q_q;
    logic             qm1_q;

    logic             accept_c;
    logic             booth_step_c;
    logic             div_load_c;
    logic             div_en_c;
    logic             div_fix_c;
    logic             last_iter_c;
    logic             b_zero_c;

    logic [WIDTH:0]   ax_c;
    logic [WIDTH:0]   bx_c;
    logic [WIDTH:0]   as_c;
    logic [RW-1:0]    as_ext_c;
    logic             as_ovf_c;

    logic [WIDTH:0]   m_ext_c;
    logic [WIDTH:0]   acc_sum_c;
    logic [WIDTH:0]   acc_n_c;
    logic [WIDTH-1:0] q_n_c;
    logic             qm1_n_c;
    logic [RW-1:0]    prod_c;

    logic             a_neg_in_c;
    logic [WIDTH-1:0] a_mag_in_c;
    logic             b_neg_c;
    logic [WIDTH-1:0] b_mag_c;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] rem_c;
    logic [WIDTH-1:0] quo_s_c;
    logic [WIDTH-1:0] rem_s_c;
    logic             div_ovf_c;

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.dbz       = dbz_q;
    assign bus.ovf       = ovf_q;

    assign b_zero_c    = (bus.b == '0);
    assign last_iter_c = (cnt_q == CNT_W'(WIDTH - 1));

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_n;
        end
    end

    // Next state and per-cycle datapath strobes.
    always_comb begin
        state_n      = state_q;
        accept_c     = 1'b0;
        booth_step_c = 1'b0;
        div_load_c   = 1'b0;
        div_en_c     = 1'b0;
        div_fix_c    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    accept_c = 1'b1;
                    if (bus.opcode == OP_MUL) begin
                        state_n = MUL;
                    end else if (bus.opcode == OP_DIV && !b_zero_c) begin
                        state_n    = DIV;
                        div_load_c = 1'b1;
                    end else begin
                        state_n = DONE;
                    end
                end
            end
            MUL: begin
                booth_step_c = 1'b1;
                if (last_iter_c) begin
                    state_n = DONE;
                end
            end
            DIV: begin
                div_en_c = 1'b1;
                if (last_iter_c) begin
                    state_n = DFIX;
                end
            end
            DFIX: begin
                div_fix_c = 1'b1;
                state_n   = DONE;
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Exact (WIDTH+1)-bit add/sub on the live request operands.
    always_comb begin
        ax_c     = bus.signed_op ? {bus.a[WIDTH-1], bus.a} : {1'b0, bus.a};
        bx_c     = bus.signed_op ? {bus.b[WIDTH-1], bus.b} : {1'b0, bus.b};
        as_c     = (bus.opcode == OP_SUB) ? (ax_c - bx_c) : (ax_c + bx_c);
        as_ext_c = bus.signed_op ? {{(WIDTH-1){as_c[WIDTH]}}, as_c}
                                 : {{(WIDTH-1){1'b0}}, as_c};
        as_ovf_c = bus.signed_op && (as_c[WIDTH] != as_c[WIDTH-1]);
    end

    // One radix-2 Booth step over {acc, q, qm1}; the unsigned zero-extension
    // bit contributes one extra +M*2^WIDTH digit, folded into the final product.
    always_comb begin
        m_ext_c = sgn_q ? {a_q[WIDTH-1], a_q} : {1'b0, a_q};
        unique case ({q_q[0], qm1_q})
            2'b01:   acc_sum_c = acc_q + m_ext_c;
            2'b10:   acc_sum_c = acc_q - m_ext_c;
            default: acc_sum_c = acc_q;
        endcase
        acc_n_c = {acc_sum_c[WIDTH], acc_sum_c[WIDTH:1]};
        q_n_c   = {acc_sum_c[0], q_q[WIDTH-1:1]};
        qm1_n_c = q_q[0];
        prod_c  = {acc_n_c[WIDTH-1:0], q_n_c}
                + ((!sgn_q && b_q[WIDTH-1]) ? {a_q, WIDTH'(0)} : RW'(0));
    end

    // Magnitudes into the divider and sign restoration of its results.
    always_comb begin
        a_neg_in_c = bus.signed_op && bus.a[WIDTH-1];
        a_mag_in_c = a_neg_in_c ? (WIDTH'(0) - bus.a) : bus.a;
        b_neg_c    = sgn_q && b_q[WIDTH-1];
        b_mag_c    = b_neg_c ? (WIDTH'(0) - b_q) : b_q;
        quo_s_c    = (sgn_q && (a_q[WIDTH-1] ^ b_q[WIDTH-1])) ? (WIDTH'(0) - quo) : quo;
        rem_s_c    = (sgn_q && a_q[WIDTH-1]) ? (WIDTH'(0) - rem_c) : rem_c;
        div_ovf_c  = sgn_q && (a_q == {1'b1, {(WIDTH-1){1'b0}}}) && (&b_q);
    end

    alu_nr_div #(
        .WIDTH (WIDTH)
    ) u_div (
        .clk      (clk),
        .reset    (reset),
        .load     (div_load_c),
        .en       (div_en_c),
        .fix      (div_fix_c),
        .dividend (a_mag_in_c),
        .divisor  (b_mag_c),
        .quo      (quo),
        .rem_c    (rem_c)
    );

    // Operand capture, Booth registers, iteration counter and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            dbz_q       <= 1'b0;
            ovf_q       <= 1'b0;
            sgn_q       <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            cnt_q       <= '0;
            acc_q       <= '0;
            q_q         <= '0;
            qm1_q       <= 1'b0;
        end else begin
            in_ready_q  <= (state_n == IDLE);
            out_valid_q <= (state_n == DONE);
            if (accept_c) begin
                sgn_q    <= bus.signed_op;
                a_q      <= bus.a;
                b_q      <= bus.b;
                cnt_q    <= '0;
                acc_q    <= '0;
                q_q      <= bus.b;
                qm1_q    <= 1'b0;
                result_q <= '0;
                dbz_q    <= 1'b0;
                ovf_q    <= 1'b0;
                if (bus.opcode == OP_ADD || bus.opcode == OP_SUB) begin
                    result_q <= as_ext_c;
                    ovf_q    <= as_ovf_c;
                end else if (bus.opcode == OP_DIV && b_zero_c) begin
                    result_q <= {bus.a, {WIDTH{1'b1}}};
                    dbz_q    <= 1'b1;
                end
            end
            if (booth_step_c) begin
                acc_q <= acc_n_c;
                q_q   <= q_n_c;
                qm1_q <= qm1_n_c;
                cnt_q <= cnt_q + CNT_W'(1);
                if (last_iter_c) begin
                    result_q <= prod_c;
                end
            end
            if (div_en_c) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
            if (div_fix_c) begin
                result_q <= {rem_s_c, quo_s_c};
                ovf_q    <= div_ovf_c;
            end
        end
    end

endmodule

// File: tb/tb_alu_seq_core.sv
// Self-checking bench for alu_seq_core: directed vectors, handshake/reset sequences, random ops.
module tb_alu_seq_core;
    import alu_seq_pkg::*;

    localparam int unsigned W  = 8;
    localparam int unsigned RW = 2 * W;
    localparam longint MAXS = (longint'(1) << (W - 1)) - 1;
    localparam longint MINS = -(longint'(1) << (W - 1));

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    alu_seq_if #(.WIDTH(W)) bus ();

    alu_seq_core #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]    op;
        logic          sg;
        logic [W-1:0]  a;
        logic [W-1:0]  b;
        logic [RW-1:0] res;
        logic          dbz;
        logic          ovf;
        int            lat;
    } vec_t;

    vec_t vecs[13];

    task automatic check(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference model from arithmetic rules on integer values.
    function automatic void model(input logic [1:0] op, input logic sg,
                                  input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [RW-1:0] res, output logic dbz,
                                  output logic ovf, output int lat);
        longint sa, sb, r, q, m;
        sa  = sg ? longint'($signed(a)) : longint'(a);
        sb  = sg ? longint'($signed(b)) : longint'(b);
        dbz = 1'b0;
        ovf = 1'b0;
        res = '0;
        lat = 1;
        if (op == OP_ADD || op == OP_SUB) begin
            r = (op == OP_SUB) ? sa - sb : sa + sb;
            if (sg) begin
                res = RW'(r);
                ovf = (r > MAXS) || (r < MINS);
            end else begin
                res = RW'(r & ((longint'(1) << (W + 1)) - 1));
            end
        end else if (op == OP_MUL) begin
            r   = sa * sb;
            res = RW'(r);
            lat = W + 1;
        end else if (b == '0) begin
            res = {a, {W{1'b1}}};
            dbz = 1'b1;
        end else begin
            q   = sa / sb;
            m   = sa % sb;
            res = {W'(m), W'(q)};
            ovf = sg && (q > MAXS);
            lat = W + 2;
        end
    endfunction

    task automatic run_op(input string nm, input logic [1:0] op, input logic sg,
                          input logic [W-1:0] av, input logic [W-1:0] bv,
                          input logic [RW-1:0] er, input logic ed, input logic eo,
                          input int el, input int hold);
        int n;
        n = 0;
        while (!bus.in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check($sformatf("%s in_ready_idle", nm), longint'(bus.in_ready), 1);
        bus.in_valid  = 1'b1;
        bus.opcode    = op;
        bus.signed_op = sg;
        bus.a         = av;
        bus.b         = bv;
        @(posedge clk); #1;
        bus.in_valid  = 1'b0;
        bus.opcode    = 2'($urandom);
        bus.signed_op = 1'($urandom);
        bus.a         = W'($urandom);
        bus.b         = W'($urandom);
        check($sformatf("%s in_ready_busy", nm), longint'(bus.in_ready), 0);
        n = 0;
        while (!bus.out_valid && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check($sformatf("%s latency", nm), longint'(n + 1), longint'(el));
        check($sformatf("%s result", nm), longint'(bus.result), longint'(er));
        check($sformatf("%s dbz", nm), longint'(bus.dbz), longint'(ed));
        check($sformatf("%s ovf", nm), longint'(bus.ovf), longint'(eo));
        for (int i = 0; i < hold; i++) begin
            bus.in_valid = 1'b1;
            bus.opcode   = 2'($urandom);
            @(posedge clk); #1;
            check($sformatf("%s hold_valid", nm), longint'(bus.out_valid), 1);
            check($sformatf("%s hold_in_ready", nm), longint'(bus.in_ready), 0);
            check($sformatf("%s hold_result", nm), longint'(bus.result), longint'(er));
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        check($sformatf("%s release_valid", nm), longint'(bus.out_valid), 0);
        check($sformatf("%s release_ready", nm), longint'(bus.in_ready), 1);
    endtask

    initial begin
        logic [RW-1:0] er;
        logic          ed;
        logic          eo;
        int            el;
        logic [1:0]    op;
        logic          sg;
        logic [W-1:0]  av;
        logic [W-1:0]  bv;

        checks        = 0;
        errors        = 0;
        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.opcode    = OP_ADD;
        bus.signed_op = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.out_ready = 1'b0;

        vecs[0]  = '{OP_ADD, 1'b0, 8'd200, 8'd100, 16'h012C, 1'b0, 1'b0, 1};
        vecs[1]  = '{OP_SUB, 1'b0, 8'd4,   8'd10,  16'h01FA, 1'b0, 1'b0, 1};
        vecs[2]  = '{OP_ADD, 1'b1, 8'd100, 8'd100, 16'h00C8, 1'b0, 1'b1, 1};
        vecs[3]  = '{OP_SUB, 1'b1, 8'd4,   8'd10,  16'hFFFA, 1'b0, 1'b0, 1};
        vecs[4]  = '{OP_MUL, 1'b0, 8'd200, 8'd200, 16'h9C40, 1'b0, 1'b0, 9};
        vecs[5]  = '{OP_MUL, 1'b1, 8'hF9,  8'd3,   16'hFFEB, 1'b0, 1'b0, 9};
        vecs[6]  = '{OP_DIV, 1'b0, 8'd20,  8'd3,   16'h0206, 1'b0, 1'b0, 10};
        vecs[7]  = '{OP_DIV, 1'b1, 8'hEC,  8'd3,   16'hFEFA, 1'b0, 1'b0, 10};
        vecs[8]  = '{OP_DIV, 1'b1, 8'h80,  8'hFF,  16'h0080, 1'b0, 1'b1, 10};
        vecs[9]  = '{OP_DIV, 1'b0, 8'd20,  8'd0,   16'h14FF, 1'b1, 1'b0, 1};
        vecs[10] = '{OP_MUL, 1'b1, 8'h80,  8'h80,  16'h4000, 1'b0, 1'b0, 9};
        vecs[11] = '{OP_MUL, 1'b0, 8'hFF,  8'hFF,  16'hFE01, 1'b0, 1'b0, 9};
        vecs[12] = '{OP_ADD, 1'b1, 8'h80,  8'hFF,  16'hFF7F, 1'b0, 1'b1, 1};

        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        check("reset in_ready", longint'(bus.in_ready), 1);
        check("reset out_valid", longint'(bus.out_valid), 0);
        check("reset result", longint'(bus.result), 0);
        check("reset dbz", longint'(bus.dbz), 0);
        check("reset ovf", longint'(bus.ovf), 0);

        // Directed vectors.
        foreach (vecs[i]) begin
            run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].sg, vecs[i].a, vecs[i].b,
                   vecs[i].res, vecs[i].dbz, vecs[i].ovf, vecs[i].lat, 0);
        end

        // Backpressure for 5 cycles with new requests offered during DONE.
        run_op("bp_add", OP_ADD, 1'b0, 8'd7, 8'd9, 16'h0010, 1'b0, 1'b0, 1, 5);
        check("bp no_extra_accept", longint'(bus.out_valid), 0);
        @(posedge clk); #1;
        check("bp still_idle", longint'(bus.out_valid), 0);

        // Reset pulsed on cycle 4 of a multiply.
        bus.in_valid  = 1'b1;
        bus.opcode    = OP_MUL;
        bus.signed_op = 1'b0;
        bus.a         = 8'd13;
        bus.b         = 8'd11;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        check("midrst in_ready", longint'(bus.in_ready), 1);
        check("midrst out_valid", longint'(bus.out_valid), 0);
        check("midrst result", longint'(bus.result), 0);
        check("midrst dbz", longint'(bus.dbz), 0);
        check("midrst ovf", longint'(bus.ovf), 0);
        @(posedge clk); #1;
        reset = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (bus.out_valid) begin
                check("midrst stale_result", longint'(bus.out_valid), 0);
            end
        end
        run_op("post_rst_add", OP_ADD, 1'b0, 8'd50, 8'd60, 16'h006E, 1'b0, 1'b0, 1, 0);

        // Random operations against the reference model.
        for (int i = 0; i < 150; i++) begin
            op = 2'($urandom_range(0, 3));
            sg = 1'($urandom);
            av = W'($urandom);
            bv = ($urandom_range(0, 7) == 0) ? W'(0) : W'($urandom);
            if ($urandom_range(0, 9) == 0) av = {1'b1, {(W-1){1'b0}}};
            if ($urandom_range(0, 9) == 0) bv = {W{1'b1}};
            model(op, sg, av, bv, er, ed, eo, el);
            run_op($sformatf("rnd%0d op%0d s%0d %0h,%0h", i, op, sg, av, bv),
                   op, sg, av, bv, er, ed, eo, el, $urandom_range(0, 2));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
